// File: rtl/rv32i_cpu_pkg.sv
// Shared RV32I encodings, CSR number and MMIO counter addresses for the rv32i_cpu hierarchy.
package rv32i_cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [11:0] CSR_TOHOST = 12'h51e;

  localparam logic [31:0] IO_CYCLE_CNT   = 32'h8000_0010;
  localparam logic [31:0] IO_INSTR_CNT   = 32'h8000_0014;
  localparam logic [31:0] IO_CNT_CLEAR   = 32'h8000_0018;
  localparam logic [31:0] IO_BRANCH_CNT  = 32'h8000_001c;
  localparam logic [31:0] IO_CORRECT_CNT = 32'h8000_0020;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LBU:  return {24'b0, b};
      F3_LHU:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_cpu_mem.sv
// Generic memory: two asynchronous read ports and one synchronous byte-enabled write port.
module mem_block #(
  parameter  int unsigned DEPTH = 16384,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned NB    = WIDTH / 8
) (
  input  logic             clk,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wbe
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core with IMEM/DMEM/RF, tohost CSR and MMIO performance counters.
// Define MMIO_BRANCH_CNTR_EN to build the branch and correct-prediction counters.
import rv32i_cpu_pkg::*;

module rv32i_cpu #(
  parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
  parameter logic [31:0] RESET_PC       = 32'h1000_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic bp_enable,
  input  logic serial_in,
  output logic serial_out
);

  logic [31:0] pc, pc_next, inst, tohost;
  logic [31:0] cycle_cnt, instr_cnt;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  logic [31:0] rf_rdata1, rf_rdata2, rs1_val, rs2_val, wb_data;
  logic        wb_en, rf_we;
  logic [31:0] imem_unused_data, dmem_unused_data, dmem_rdata;
  logic [31:0] mem_addr, io_addr, io_rdata, load_word, st_data;
  logic [3:0]  st_be;
  logic        is_store, dmem_sel, io_sel, dmem_we, cnt_clear;

  mem_block #(.DEPTH(16384), .WIDTH(32)) imem (
    .clk(clk), .raddr0(pc[15:2]), .rdata0(inst), .raddr1('0), .rdata1(imem_unused_data),
    .we(1'b0), .waddr('0), .wdata('0), .wbe('0)
  );

  mem_block #(.DEPTH(16384), .WIDTH(32)) dmem (
    .clk(clk), .raddr0(mem_addr[15:2]), .rdata0(dmem_rdata), .raddr1('0),
    .rdata1(dmem_unused_data), .we(dmem_we), .waddr(mem_addr[15:2]), .wdata(st_data),
    .wbe(st_be)
  );

  mem_block #(.DEPTH(32), .WIDTH(32)) rf (
    .clk(clk), .raddr0(rs1), .rdata0(rf_rdata1), .raddr1(rs2), .rdata1(rf_rdata2),
    .we(rf_we), .waddr(rd), .wdata(wb_data), .wbe(4'b1111)
  );

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_rdata1;
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_rdata2;

  logic [31:0] alu_b, alu_out;
  logic        alt;
  always_comb begin
    alu_out = '0;
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    alt     = (funct7 == F7_ALT);
    case (funct3)
      F3_ADD:  alu_out = (opcode == OPC_OP && alt) ? rs1_val - alu_b : rs1_val + alu_b;
      F3_SLL:  alu_out = rs1_val << alu_b[4:0];
      F3_SLT:  alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      F3_SLTU: alu_out = {31'b0, rs1_val < alu_b};
      F3_XOR:  alu_out = rs1_val ^ alu_b;
      F3_SR: begin
        // Kept as separate assignments so the arithmetic shift stays in signed context.
        if (alt) alu_out = $signed(rs1_val) >>> alu_b[4:0];
        else     alu_out = rs1_val >> alu_b[4:0];
      end
      F3_OR:   alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  logic is_branch, br_taken;
  assign is_branch = (opcode == OPC_BRANCH);
  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign is_store  = (opcode == OPC_STORE);
  assign mem_addr  = rs1_val + (is_store ? imm_s : imm_i);
  assign dmem_sel  = (mem_addr[31:28] == 4'h1) || (mem_addr[31:28] == 4'h3);
  assign io_sel    = mem_addr[31];
  assign io_addr   = {mem_addr[31:2], 2'b00};
  assign dmem_we   = is_store && dmem_sel && rst;
  assign cnt_clear = is_store && io_sel && (io_addr == IO_CNT_CLEAR);

  always_comb begin
    case (funct3)
      F3_SB: begin
        st_be   = 4'b0001 << mem_addr[1:0];
        st_data = {4{rs2_val[7:0]}};
      end
      F3_SH: begin
        st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_val[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = rs2_val;
      end
    endcase
  end

`ifdef MMIO_BRANCH_CNTR_EN
  logic [31:0] branch_cnt, correct_cnt;
  logic        predict_taken;
  assign predict_taken = bp_enable & imm_b[31];

  always_ff @(posedge clk) begin
    if (!rst || cnt_clear) begin
      branch_cnt  <= '0;
      correct_cnt <= '0;
    end else if (is_branch) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (br_taken == predict_taken) correct_cnt <= correct_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    case (io_addr)
      IO_CYCLE_CNT:   io_rdata = cycle_cnt;
      IO_INSTR_CNT:   io_rdata = instr_cnt;
`ifdef MMIO_BRANCH_CNTR_EN
      IO_BRANCH_CNT:  io_rdata = branch_cnt;
      IO_CORRECT_CNT: io_rdata = correct_cnt;
`endif
      default:        io_rdata = '0;
    endcase
  end

  assign load_word = dmem_sel ? dmem_rdata : (io_sel ? io_rdata : '0);

  always_comb begin
    pc_next = pc + 32'd4;
    wb_en   = 1'b0;
    wb_data = alu_out;
    case (opcode)
      OPC_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
      OPC_AUIPC: begin wb_en = 1'b1; wb_data = pc + imm_u; end
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      OPC_JALR: begin
        wb_en   = 1'b1;
        wb_data = pc + 32'd4;
        pc_next = (rs1_val + imm_i) & 32'hFFFF_FFFE;
      end
      OPC_BRANCH: if (br_taken) pc_next = pc + imm_b;
      OPC_LOAD: begin
        wb_en   = 1'b1;
        wb_data = load_extend(funct3, load_word, mem_addr[1:0]);
      end
      OPC_OP_IMM, OPC_OP: wb_en = 1'b1;
      default: ;
    endcase
  end

  assign rf_we = wb_en && (rd != 5'd0) && rst;

  logic        csr_we;
  logic [31:0] csr_wdata;
  assign csr_we    = (opcode == OPC_SYSTEM) && (inst[31:20] == CSR_TOHOST) &&
                     ((funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI));
  assign csr_wdata = (funct3 == F3_CSRRWI) ? {27'b0, rs1} : rs1_val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= RESET_PC;
      tohost    <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      pc <= pc_next;
      if (csr_we) tohost <= csr_wdata;
      if (cnt_clear) begin
        cycle_cnt <= '0;
        instr_cnt <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
        instr_cnt <= instr_cnt + 32'd1;
      end
    end
  end

  assign serial_out = 1'b1;

  logic unused_ok;
`ifdef MMIO_BRANCH_CNTR_EN
  assign unused_ok = ^{serial_in, CPU_CLOCK_FREQ[0], imem_unused_data, dmem_unused_data};
`else
  assign unused_ok = ^{serial_in, bp_enable, CPU_CLOCK_FREQ[0], imem_unused_data,
                       dmem_unused_data};
`endif

endmodule

// File: tb/tb_rv32i_cpu.sv
// Self-checking bench for rv32i_cpu: directed programs plus randomized ALU and memory programs
// checked against an instruction-level reference model.
module tb_rv32i_cpu;

  localparam logic [31:0] RESET_PC = 32'h1000_0000;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011, OP_LOAD = 7'b0000011, OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bp_enable = 1'b0;
  logic serial_in = 1'b1;
  logic serial_out;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] prog[$];
  int alu_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  rv32i_cpu #(.CPU_CLOCK_FREQ(50_000_000), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .bp_enable(bp_enable), .serial_in(serial_in), .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP_REG};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] ref_alu(int k, logic [31:0] a, logic [31:0] b);
    int unsigned sh = b & 32'd31;
    case (k)
      0: return a + b;
      1: return a - b;
      2: return a << sh;
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> sh;
      7: return $signed(a) >>> sh;
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Loads the program followed by a self-loop, holds reset two cycles, releases it at negedge.
  task automatic start_prog();
    int base = (RESET_PC >> 2) & 16383;
    rst = 1'b0;
    for (int i = 0; i < prog.size(); i++) dut.imem.mem[base + i] = prog[i];
    dut.imem.mem[base + prog.size()] = 32'h0000_006f;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_tohost();
    logic [31:0] v = $urandom;
    prog.delete();
    dut.rf.mem[6] = v;
    dut.rf.mem[5] = 32'h0000_5555;
    prog.push_back(enc_i(12'h51e, 1, 5, 0, OP_SYS));
    prog.push_back(enc_i(12'h51e, 0, 5, 0, OP_SYS));
    prog.push_back(enc_i(12'h51e, 6, 1, 5, OP_SYS));
    prog.push_back(enc_i(12'h51f, 7, 5, 0, OP_SYS));
    start_prog();
    run_cycles(1);
    n_tests++; if (dut.tohost !== 32'd1) begin n_fail++;
      $display("FAIL tohost_csrrwi1: got %h expected %h", dut.tohost, 32'd1); end
    run_cycles(1);
    n_tests++; if (dut.tohost !== 32'd0) begin n_fail++;
      $display("FAIL tohost_csrrwi0: got %h expected %h", dut.tohost, 32'd0); end
    run_cycles(1);
    n_tests++; if (dut.tohost !== v) begin n_fail++;
      $display("FAIL tohost_csrrw: got %h expected %h", dut.tohost, v); end
    run_cycles(1);
    n_tests++; if (dut.tohost !== v) begin n_fail++;
      $display("FAIL tohost_other_csr: got %h expected %h", dut.tohost, v); end
    n_tests++; if (dut.rf.mem[5] !== 32'h0000_5555) begin n_fail++;
      $display("FAIL csr_no_rd: got %h expected %h", dut.rf.mem[5], 32'h0000_5555); end
    rst = 1'b0;
    run_cycles(1);
    n_tests++; if (dut.tohost !== 32'd0) begin n_fail++;
      $display("FAIL tohost_in_reset: got %h expected %h", dut.tohost, 32'd0); end
  endtask

  task automatic test_reset();
    prog.delete();
    dut.rf.mem[12] = 32'd5;
    prog.push_back(enc_i(99, 0, 0, 12, OP_IMM));
    start_prog();
    rst = 1'b0;
    run_cycles(3);
    n_tests++; if (dut.pc !== RESET_PC) begin n_fail++;
      $display("FAIL reset_pc: got %h expected %h", dut.pc, RESET_PC); end
    n_tests++; if (dut.rf.mem[12] !== 32'd5) begin n_fail++;
      $display("FAIL reset_no_rf_write: got %h expected %h", dut.rf.mem[12], 32'd5); end
    n_tests++; if (serial_out !== 1'b1) begin n_fail++;
      $display("FAIL serial_idle: got %b expected 1", serial_out); end
    rst = 1'b1;
    run_cycles(1);
    n_tests++; if (dut.rf.mem[12] !== 32'd99) begin n_fail++;
      $display("FAIL first_instr: got %h expected %h", dut.rf.mem[12], 32'd99); end
    n_tests++; if (dut.pc !== RESET_PC + 32'd4) begin n_fail++;
      $display("FAIL first_pc: got %h expected %h", dut.pc, RESET_PC + 32'd4); end
  endtask

  task automatic push_counter_loads();
    prog.push_back(enc_i(16, 5, 2, 7, OP_LOAD));
    prog.push_back(enc_i(20, 5, 2, 8, OP_LOAD));
    prog.push_back(enc_i(28, 5, 2, 9, OP_LOAD));
    prog.push_back(enc_i(32, 5, 2, 10, OP_LOAD));
  endtask

  task automatic test_counters();
    prog.delete();
    prog.push_back(enc_u(20'h80000, 5, OP_LUI));
    prog.push_back(enc_s(24, 0, 5, 2));
    for (int i = 0; i < 10; i++) prog.push_back(enc_i(0, 0, 0, 0, OP_IMM));
    push_counter_loads();
    start_prog();
    run_cycles(25);
    n_tests++; if (dut.rf.mem[7] !== 32'd10) begin n_fail++;
      $display("FAIL cnt_cycle: got %0d expected 10", dut.rf.mem[7]); end
    n_tests++; if (dut.rf.mem[8] !== 32'd11) begin n_fail++;
      $display("FAIL cnt_instr: got %0d expected 11", dut.rf.mem[8]); end
    n_tests++; if (dut.rf.mem[9] !== 32'd0) begin n_fail++;
      $display("FAIL cnt_branch_none: got %0d expected 0", dut.rf.mem[9]); end
    n_tests++; if (dut.rf.mem[10] !== 32'd0) begin n_fail++;
      $display("FAIL cnt_correct_none: got %0d expected 0", dut.rf.mem[10]); end
  endtask

  task automatic test_branch_loop(input logic bp, input int n);
    logic [31:0] exp_br, exp_ok;
    prog.delete();
    bp_enable = bp;
    prog.push_back(enc_u(20'h80000, 5, OP_LUI));
    prog.push_back(enc_s(24, 0, 5, 2));
    prog.push_back(enc_i(n, 0, 0, 11, OP_IMM));
    prog.push_back(enc_i(-1, 11, 0, 11, OP_IMM));
    prog.push_back(enc_b(-4, 0, 11, 1));
    push_counter_loads();
    start_prog();
    run_cycles(2 * n + 20);
`ifdef MMIO_BRANCH_CNTR_EN
    exp_br = n;
    exp_ok = bp ? n - 1 : 1;
`else
    exp_br = 0;
    exp_ok = 0;
`endif
    n_tests++; if (dut.rf.mem[7] !== 32'(1 + 2 * n)) begin n_fail++;
      $display("FAIL loop_cycle bp=%0b n=%0d: got %0d expected %0d", bp, n, dut.rf.mem[7], 1 + 2 * n); end
    n_tests++; if (dut.rf.mem[8] !== 32'(2 + 2 * n)) begin n_fail++;
      $display("FAIL loop_instr bp=%0b n=%0d: got %0d expected %0d", bp, n, dut.rf.mem[8], 2 + 2 * n); end
    n_tests++; if (dut.rf.mem[9] !== exp_br) begin n_fail++;
      $display("FAIL loop_branch bp=%0b n=%0d: got %0d expected %0d", bp, n, dut.rf.mem[9], exp_br); end
    n_tests++; if (dut.rf.mem[10] !== exp_ok) begin n_fail++;
      $display("FAIL loop_correct bp=%0b n=%0d: got %0d expected %0d", bp, n, dut.rf.mem[10], exp_ok); end
    bp_enable = 1'b0;
  endtask

  task automatic test_subword_mem();
    prog.delete();
    dut.dmem.mem[0] = 32'h8081_8283;
    prog.push_back(enc_u(20'h10000, 5, OP_LUI));
    prog.push_back(enc_i(0, 5, 0, 6, OP_LOAD));
    prog.push_back(enc_i(0, 5, 4, 7, OP_LOAD));
    prog.push_back(enc_i(0, 5, 1, 8, OP_LOAD));
    prog.push_back(enc_i(2, 5, 5, 9, OP_LOAD));
    prog.push_back(enc_i(12'h55, 0, 0, 10, OP_IMM));
    prog.push_back(enc_s(1, 10, 5, 0));
    start_prog();
    run_cycles(10);
    n_tests++; if (dut.rf.mem[6] !== 32'hFFFF_FF83) begin n_fail++;
      $display("FAIL lb: got %h expected %h", dut.rf.mem[6], 32'hFFFF_FF83); end
    n_tests++; if (dut.rf.mem[7] !== 32'h0000_0083) begin n_fail++;
      $display("FAIL lbu: got %h expected %h", dut.rf.mem[7], 32'h0000_0083); end
    n_tests++; if (dut.rf.mem[8] !== 32'hFFFF_8283) begin n_fail++;
      $display("FAIL lh: got %h expected %h", dut.rf.mem[8], 32'hFFFF_8283); end
    n_tests++; if (dut.rf.mem[9] !== 32'h0000_8081) begin n_fail++;
      $display("FAIL lhu: got %h expected %h", dut.rf.mem[9], 32'h0000_8081); end
    n_tests++; if (dut.dmem.mem[0] !== 32'h8081_5583) begin n_fail++;
      $display("FAIL sb: got %h expected %h", dut.dmem.mem[0], 32'h8081_5583); end
  endtask

  task automatic test_x0_jal();
    prog.delete();
    dut.rf.mem[0] = '0;
    dut.rf.mem[12] = 32'h1234;
    dut.rf.mem[13] = 32'h1234;
    dut.rf.mem[17] = 32'h1234;
    dut.rf.mem[16] = RESET_PC + 32'd30;
    prog.push_back(enc_i(5, 0, 0, 0, OP_IMM));
    prog.push_back(enc_j(8, 0));
    prog.push_back(enc_i(1, 0, 0, 12, OP_IMM));
    prog.push_back(enc_j(8, 1));
    prog.push_back(enc_i(1, 0, 0, 13, OP_IMM));
    prog.push_back(enc_i(7, 0, 0, 14, OP_IMM));
    prog.push_back(enc_i(3, 16, 0, 15, OP_JALR));
    prog.push_back(enc_i(1, 0, 0, 17, OP_IMM));
    prog.push_back(enc_i(9, 0, 0, 18, OP_IMM));
    start_prog();
    run_cycles(12);
    n_tests++; if (dut.rf.mem[0] !== 32'd0) begin n_fail++;
      $display("FAIL x0_write: got %h expected 0", dut.rf.mem[0]); end
    n_tests++; if (dut.rf.mem[12] !== 32'h1234) begin n_fail++;
      $display("FAIL jal_x0_skip: got %h expected %h", dut.rf.mem[12], 32'h1234); end
    n_tests++; if (dut.rf.mem[1] !== RESET_PC + 32'd16) begin n_fail++;
      $display("FAIL jal_link: got %h expected %h", dut.rf.mem[1], RESET_PC + 32'd16); end
    n_tests++; if (dut.rf.mem[13] !== 32'h1234) begin n_fail++;
      $display("FAIL jal_skip: got %h expected %h", dut.rf.mem[13], 32'h1234); end
    n_tests++; if (dut.rf.mem[14] !== 32'd7) begin n_fail++;
      $display("FAIL jal_target: got %h expected 7", dut.rf.mem[14]); end
    n_tests++; if (dut.rf.mem[15] !== RESET_PC + 32'd28) begin n_fail++;
      $display("FAIL jalr_link: got %h expected %h", dut.rf.mem[15], RESET_PC + 32'd28); end
    n_tests++; if (dut.rf.mem[17] !== 32'h1234) begin n_fail++;
      $display("FAIL jalr_skip: got %h expected %h", dut.rf.mem[17], 32'h1234); end
    n_tests++; if (dut.rf.mem[18] !== 32'd9) begin n_fail++;
      $display("FAIL jalr_target: got %h expected 9", dut.rf.mem[18]); end
  endtask

  task automatic test_random_alu();
    logic [31:0] m[32];
    logic [31:0] b, res, pcv;
    int k, rd, rs1, rs2, imm, sel;
    prog.delete();
    dut.rf.mem[0] = 32'hDEAD_BEEF;
    m[0] = '0;
    for (int i = 1; i < 32; i++) begin
      m[i] = $urandom;
      dut.rf.mem[i] = m[i];
    end
    for (int n = 0; n < 60; n++) begin
      pcv = RESET_PC + 32'(4 * n);
      sel = $urandom_range(0, 4);
      rd = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      k = $urandom_range(0, 9);
      if (sel <= 1) begin
        prog.push_back(enc_r((k == 1 || k == 7) ? 32 : 0, rs2, rs1, alu_f3[k], rd));
        res = ref_alu(k, m[rs1], m[rs2]);
      end else if (sel <= 3) begin
        if (k == 1) k = 0;
        if (k == 2 || k == 6 || k == 7) imm = $urandom_range(0, 31) | ((k == 7) ? 32'h400 : 0);
        else imm = $urandom_range(0, 4095);
        b = {{20{imm[11]}}, imm[11:0]};
        prog.push_back(enc_i(imm, rs1, alu_f3[k], rd, OP_IMM));
        res = ref_alu(k, m[rs1], b);
      end else begin
        imm = $urandom_range(0, 20'hFFFFF);
        b = imm << 12;
        if (k < 5) begin
          prog.push_back(enc_u(imm, rd, OP_LUI));
          res = b;
        end else begin
          prog.push_back(enc_u(imm, rd, OP_AUIPC));
          res = b + pcv;
        end
      end
      if (rd != 0) m[rd] = res;
    end
    start_prog();
    run_cycles(70);
    for (int i = 1; i < 32; i++) begin
      n_tests++; if (dut.rf.mem[i] !== m[i]) begin n_fail++;
        $display("FAIL rand_alu x%0d: got %h expected %h", i, dut.rf.mem[i], m[i]); end
    end
  endtask

  task automatic test_random_mem();
    logic [31:0] rm[32];
    logic [31:0] mw[16];
    logic [31:0] w, v;
    int op, rd, rs2, off, sh, idx;
    int ld_f3[5] = '{0, 1, 2, 4, 5};
    prog.delete();
    rm[5] = 32'h1000_0000;
    rm[4] = 32'h2000_0000;
    for (int i = 6; i < 32; i++) begin rm[i] = $urandom; dut.rf.mem[i] = rm[i]; end
    for (int i = 0; i < 16; i++) begin mw[i] = $urandom; dut.dmem.mem[i] = mw[i]; end
    prog.push_back(enc_u(20'h10000, 5, OP_LUI));
    prog.push_back(enc_u(20'h20000, 4, OP_LUI));
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 8);
      rd = $urandom_range(6, 31);
      rs2 = $urandom_range(6, 31);
      off = $urandom_range(0, 63);
      if (op == 1 || op == 4 || op == 6) off = off & ~1;
      if (op == 2 || op == 7) off = off & ~3;
      idx = off / 4;
      sh = (off % 4) * 8;
      if (op <= 4) begin
        prog.push_back(enc_i(off, 5, ld_f3[op], rd, OP_LOAD));
        w = mw[idx];
        v = w >> sh;
        case (op)
          0: rm[rd] = {{24{v[7]}}, v[7:0]};
          1: rm[rd] = {{16{v[15]}}, v[15:0]};
          2: rm[rd] = w;
          3: rm[rd] = {24'b0, v[7:0]};
          default: rm[rd] = {16'b0, v[15:0]};
        endcase
      end else if (op <= 7) begin
        prog.push_back(enc_s(off, rs2, 5, op - 5));
        v = rm[rs2];
        if (op == 5) mw[idx][sh +: 8] = v[7:0];
        else if (op == 6) mw[idx][sh +: 16] = v[15:0];
        else mw[idx] = v;
      end else begin
        prog.push_back(enc_i(off & ~3, 4, 2, rd, OP_LOAD));
        rm[rd] = '0;
      end
    end
    start_prog();
    run_cycles(55);
    for (int i = 6; i < 32; i++) begin
      n_tests++; if (dut.rf.mem[i] !== rm[i]) begin n_fail++;
        $display("FAIL rand_mem x%0d: got %h expected %h", i, dut.rf.mem[i], rm[i]); end
    end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (dut.dmem.mem[i] !== mw[i]) begin n_fail++;
        $display("FAIL rand_mem dmem[%0d]: got %h expected %h", i, dut.dmem.mem[i], mw[i]); end
    end
  endtask

  initial begin
    test_tohost();
    test_reset();
    test_counters();
    test_branch_loop(1'b0, 10);
    test_branch_loop(1'b1, 10);
    test_branch_loop(1'b0, $urandom_range(2, 30));
    test_branch_loop(1'b1, $urandom_range(2, 30));
    test_subword_mem();
    test_x0_jal();
    for (int r = 0; r < 3; r++) test_random_alu();
    for (int r = 0; r < 3; r++) test_random_mem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
